// File: rtl/omok_pkg.sv
// omok_pkg: shared button indices, priority order and default timing for the OMOK button conditioner.
package omok_pkg;
   localparam int NB = 6;
   localparam int DEF_DEB_CYCLES   = 4;
   localparam int DEF_REPEAT_DELAY = 20;
   localparam int DEF_REPEAT_RATE  = 8;
   typedef logic [NB-1:0] btn_vec_t;
   // Enumeration order is the arbiter priority: lowest index wins.
   typedef enum logic [2:0] {
      BTN_PUT   = 3'd0,
      BTN_UNDO  = 3'd1,
      BTN_UP    = 3'd2,
      BTN_DOWN  = 3'd3,
      BTN_LEFT  = 3'd4,
      BTN_RIGHT = 3'd5
   } btn_idx_e;
   localparam btn_vec_t DIR_MASK = 6'b111100;
   function automatic btn_vec_t prio_pick(btn_vec_t v);
      return v & (~v + btn_vec_t'(1));
   endfunction
endpackage

// File: rtl/omok_btn_cond_if.sv
// omok_btn_cond_if: raw push-button levels in, one-cycle game commands out.
interface omok_btn_cond_if;
   logic btn_left, btn_right, btn_up, btn_down, btn_put, btn_undo;
   logic left, right, up, down, put, undo;
   modport master (
      output btn_left, btn_right, btn_up, btn_down, btn_put, btn_undo,
      input  left, right, up, down, put, undo
   );
   modport slave (
      input  btn_left, btn_right, btn_up, btn_down, btn_put, btn_undo,
      output left, right, up, down, put, undo
   );
endinterface

// File: rtl/omok_debounce.sv
// omok_debounce: 2-flop synchronizer, consecutive-cycle debounce and registered rising-edge pulse for one button.
module omok_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic lvl,
   output logic rise
);
   localparam int CW = $clog2(DEB_CYCLES);
   logic s1, s2;
   logic [CW-1:0] cnt;
   logic done;
   assign done = (s2 != lvl) && (cnt == CW'(DEB_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         cnt  <= '0;
         lvl  <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         cnt  <= (s2 == lvl || done) ? '0 : cnt + CW'(1);
         lvl  <= done ? s2 : lvl;
         rise <= done & s2;
      end
   end
endmodule

// File: rtl/omok_btn_cond.sv
// omok_btn_cond: conditions six raw buttons into prioritized one-cycle command pulses with direction auto-repeat.
module omok_btn_cond
   import omok_pkg::*;
#(
   parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input logic clk,
   input logic rst,
   omok_btn_cond_if.slave bus
);
   localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HW   = $clog2(HMAX + 1);
   btn_vec_t raw, lvl, rise, rep, pend, pend_nx, grant, cmd;
   assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_undo, bus.btn_put};
   for (genvar i = 0; i < NB; i++) begin : g_btn
      omok_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw[i]),
         .lvl  (lvl[i]),
         .rise (rise[i])
      );
      if (DIR_MASK[i]) begin : g_rep
         // ph=0 waits out the initial delay, ph=1 paces the repeat rate.
         logic [HW-1:0] cnt;
         logic ph;
         assign rep[i] = lvl[i] & (cnt == (ph ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY)));
         always_ff @(posedge clk) begin
            if (rst || !lvl[i]) begin
               cnt <= '0;
               ph  <= 1'b0;
            end else begin
               cnt <= rep[i] ? HW'(1) : (&cnt ? cnt : cnt + HW'(1));
               ph  <= ph | rep[i];
            end
         end
      end else begin : g_norep
         assign rep[i] = 1'b0;
      end
   end
   // New events join the pending set in the same cycle they are arbitrated.
   assign pend_nx = pend | rise | rep;
   assign grant   = prio_pick(pend_nx);
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
         cmd  <= '0;
      end else begin
         pend <= pend_nx & ~grant;
         cmd  <= grant;
      end
   end
   assign bus.put   = cmd[BTN_PUT];
   assign bus.undo  = cmd[BTN_UNDO];
   assign bus.up    = cmd[BTN_UP];
   assign bus.down  = cmd[BTN_DOWN];
   assign bus.left  = cmd[BTN_LEFT];
   assign bus.right = cmd[BTN_RIGHT];
endmodule
